// File: rtl/cpu_control_fsm_pkg.sv
// Shared ISA definitions for the CPU controller: opcodes, ALU function codes,
// FSM state encodings and the decoded control word handed from decoder to FSM.
package cpu_control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_NEG  = 5'b00101;
    localparam logic [4:0] OP_CMP  = 5'b00110;
    localparam logic [4:0] OP_MOV  = 5'b00111;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_LDI  = 5'b01001;
    localparam logic [4:0] OP_LD   = 5'b01010;
    localparam logic [4:0] OP_ST   = 5'b01011;
    localparam logic [4:0] OP_BEQ  = 5'b01100;
    localparam logic [4:0] OP_BNE  = 5'b01101;
    localparam logic [4:0] OP_BLT  = 5'b01110;
    localparam logic [4:0] OP_JMP  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [2:0] FSEL_ADD   = 3'b000;
    localparam logic [2:0] FSEL_SUB   = 3'b001;
    localparam logic [2:0] FSEL_AND   = 3'b010;
    localparam logic [2:0] FSEL_OR    = 3'b011;
    localparam logic [2:0] FSEL_NEG   = 3'b100;
    localparam logic [2:0] FSEL_CMP   = 3'b101;
    localparam logic [2:0] FSEL_PASSX = 3'b110;
    localparam logic [2:0] FSEL_PASSY = 3'b111;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_RZ   = 2'd1,
        WB_RM   = 2'd2
    } wb_kind_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_AL   = 3'd4
    } br_cond_t;

    typedef struct packed {
        logic       ld_x_r1;
        logic       ld_x_r2;
        logic       ld_x_pc;
        logic       ld_y_r2;
        logic       ld_off11;
        logic       ld_off8;
        logic       ld_off5;
        logic [2:0] fsel;
        logic       is_mem;
        logic       is_ld;
        logic       sets_flags;
        wb_kind_t   wb_kind;
        br_cond_t   br_cond;
        logic       is_halt;
        logic       is_illegal;
    } ctrl_word_t;

    function automatic logic branch_taken(input br_cond_t cond, input logic v,
                                          input logic s, input logic z);
        case (cond)
            BR_EQ:   return z;
            BR_NE:   return ~z;
            BR_LT:   return s ^ v;
            BR_AL:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_fsm_decode.sv
// Combinational opcode decoder: maps the latched opcode to datapath selects,
// ALU function, memory/write-back kind and branch condition.
module cpu_control_fsm_decode
    import cpu_control_fsm_pkg::*;
(
    input  logic [4:0] i_op,
    output ctrl_word_t o_cw
);

    always_comb begin
        o_cw         = '0;
        o_cw.wb_kind = WB_NONE;
        o_cw.br_cond = BR_NONE;
        case (i_op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                o_cw.ld_x_r1    = 1'b1;
                o_cw.ld_y_r2    = 1'b1;
                o_cw.sets_flags = 1'b1;
                o_cw.wb_kind    = WB_RZ;
                case (i_op)
                    OP_SUB:  o_cw.fsel = FSEL_SUB;
                    OP_AND:  o_cw.fsel = FSEL_AND;
                    OP_OR:   o_cw.fsel = FSEL_OR;
                    default: o_cw.fsel = FSEL_ADD;
                endcase
            end
            OP_NEG: begin
                o_cw.ld_x_r1    = 1'b1;
                o_cw.fsel       = FSEL_NEG;
                o_cw.sets_flags = 1'b1;
                o_cw.wb_kind    = WB_RZ;
            end
            OP_CMP: begin
                o_cw.ld_x_r1    = 1'b1;
                o_cw.ld_y_r2    = 1'b1;
                o_cw.fsel       = FSEL_CMP;
                o_cw.sets_flags = 1'b1;
            end
            OP_MOV: begin
                o_cw.ld_y_r2    = 1'b1;
                o_cw.fsel       = FSEL_PASSY;
                o_cw.sets_flags = 1'b1;
                o_cw.wb_kind    = WB_RZ;
            end
            OP_ADDI: begin
                o_cw.ld_x_r1    = 1'b1;
                o_cw.ld_off8    = 1'b1;
                o_cw.fsel       = FSEL_ADD;
                o_cw.sets_flags = 1'b1;
                o_cw.wb_kind    = WB_RZ;
            end
            OP_LDI: begin
                o_cw.ld_off8 = 1'b1;
                o_cw.fsel    = FSEL_PASSY;
                o_cw.wb_kind = WB_RZ;
            end
            OP_LD, OP_ST: begin
                o_cw.ld_x_r2 = 1'b1;
                o_cw.ld_off5 = 1'b1;
                o_cw.fsel    = FSEL_ADD;
                o_cw.is_mem  = 1'b1;
                o_cw.is_ld   = (i_op == OP_LD);
                o_cw.wb_kind = (i_op == OP_LD) ? WB_RM : WB_NONE;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_JMP: begin
                // target = branch address + sext(off11); PC is not bumped until WB
                o_cw.ld_x_pc  = 1'b1;
                o_cw.ld_off11 = 1'b1;
                o_cw.fsel     = FSEL_ADD;
                case (i_op)
                    OP_BEQ:  o_cw.br_cond = BR_EQ;
                    OP_BNE:  o_cw.br_cond = BR_NE;
                    OP_BLT:  o_cw.br_cond = BR_LT;
                    default: o_cw.br_cond = BR_AL;
                endcase
            end
            OP_HALT: o_cw.is_halt = 1'b1;
            default: o_cw.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU controller (FETCH/DECODE/EXEC/MEM/WB/HALT) with flag register
// and retired-instruction counter. Define CTRL_ILLEGAL_TRAP_EN to halt on undefined opcodes.
//
// state  | meaning
// FETCH  | idle; latch opcode and advance when run=1
// DECODE | read r1/r2; HALT (or trapped illegal) goes to HALT
// EXEC   | ALU operation; flags and branch decision captured on exit
// MEM    | LD/ST memory access, Z holds address
// WB     | PC update, register write-back, count retired instruction
// HALT   | sticky stop, left only by rst
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [4:0]         opcode,
    input  logic               C,
    input  logic               V,
    input  logic               S,
    input  logic               Z_det,
    output logic               ldPC2,
    output logic               ldPCz,
    output logic               ldXr1,
    output logic               ldXr2,
    output logic               ldXPC,
    output logic               ldYr1,
    output logic               ldYr2,
    output logic               alu_ld,
    output logic               ldRPC,
    output logic               ldRZ,
    output logic               ldRM,
    output logic               rdr1,
    output logic               rdr2,
    output logic               rdm,
    output logic               wrm,
    output logic               ldOff11to16,
    output logic               ldOff8to16,
    output logic               ldOff5to16,
    output logic [2:0]         fsel,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic LP_ILLEGAL_TRAP = 1'b1;
`else
    localparam logic LP_ILLEGAL_TRAP = 1'b0;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_op;
    logic [3:0]         r_flags;   // {c,v,s,z}
    logic               r_br_taken;
    logic [COUNT_W-1:0] r_count;
    logic               r_halted;
    logic               r_illegal;
    ctrl_word_t         w_cw;
    logic               w_to_halt;
    logic               w_unused_c;

    cpu_control_fsm_decode u_decode (
        .i_op (r_op),
        .o_cw (w_cw)
    );

    assign w_to_halt  = w_cw.is_halt | (LP_ILLEGAL_TRAP & w_cw.is_illegal);
    assign w_unused_c = r_flags[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_op       <= '0;
            r_flags    <= '0;
            r_br_taken <= 1'b0;
            r_count    <= '0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_FETCH && run) begin
                r_op <= opcode;
            end
            if (r_state == ST_DECODE) begin
                if (w_cw.is_illegal) r_illegal <= 1'b1;
                if (w_to_halt)       r_halted  <= 1'b1;
            end
            if (r_state == ST_EXEC) begin
                if (w_cw.sets_flags) r_flags <= {C, V, S, Z_det};
                // decided on the flags left by the previous instruction
                r_br_taken <= branch_taken(w_cw.br_cond, r_flags[2], r_flags[1], r_flags[0]);
            end
            if (r_state == ST_WB) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH:  if (run) w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = w_to_halt ? ST_HALT : ST_EXEC;
            ST_EXEC:   w_state_nxt = w_cw.is_mem ? ST_MEM : ST_WB;
            ST_MEM:    w_state_nxt = ST_WB;
            ST_WB:     w_state_nxt = ST_FETCH;
            ST_HALT:   w_state_nxt = ST_HALT;
            default:   w_state_nxt = ST_FETCH;
        endcase
    end

    // rst forces every strobe low in the same cycle, aborting any instruction
    always_comb begin
        ldPC2       = 1'b0;
        ldPCz       = 1'b0;
        ldXr1       = 1'b0;
        ldXr2       = 1'b0;
        ldXPC       = 1'b0;
        ldYr2       = 1'b0;
        alu_ld      = 1'b0;
        ldRZ        = 1'b0;
        ldRM        = 1'b0;
        rdr1        = 1'b0;
        rdr2        = 1'b0;
        rdm         = 1'b0;
        wrm         = 1'b0;
        ldOff11to16 = 1'b0;
        ldOff8to16  = 1'b0;
        ldOff5to16  = 1'b0;
        fsel        = FSEL_ADD;
        if (!rst) begin
            case (r_state)
                ST_DECODE: begin
                    rdr1 = 1'b1;
                    rdr2 = 1'b1;
                end
                ST_EXEC: begin
                    rdr1        = 1'b1;
                    rdr2        = 1'b1;
                    alu_ld      = 1'b1;
                    ldXr1       = w_cw.ld_x_r1;
                    ldXr2       = w_cw.ld_x_r2;
                    ldXPC       = w_cw.ld_x_pc;
                    ldYr2       = w_cw.ld_y_r2;
                    ldOff11to16 = w_cw.ld_off11;
                    ldOff8to16  = w_cw.ld_off8;
                    ldOff5to16  = w_cw.ld_off5;
                    fsel        = w_cw.fsel;
                end
                ST_MEM: begin
                    rdr1 = 1'b1;
                    rdm  = w_cw.is_ld;
                    wrm  = ~w_cw.is_ld;
                end
                ST_WB: begin
                    ldPCz = r_br_taken;
                    ldPC2 = ~r_br_taken;
                    ldRZ  = (w_cw.wb_kind == WB_RZ);
                    ldRM  = (w_cw.wb_kind == WB_RM);
                end
                default: ;
            endcase
        end
    end

    assign ldYr1       = 1'b0;
    assign ldRPC       = 1'b0;
    assign halted      = r_halted;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule
